// File: rtl/button_event_scheduler_pkg.sv
// rtl/button_event_scheduler_pkg.sv - shared types and constants for the button event scheduler
package button_pkg;

   localparam int NUM_SRC = 4;
   localparam int SRC_W   = 2;

   typedef enum logic [SRC_W-1:0] {
      DAYNIGHT = 2'd0,
      MODE     = 2'd1,
      TRIP     = 2'd2,
      SETTING  = 2'd3
   } src_e;

   localparam logic [1:0] REG_EVENT  = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_MASK   = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   localparam int VALID_BIT   = 31;
   localparam int OVF_BIT     = 16;
   localparam int PEND_LSB    = 8;
   localparam int FLUSH_BIT   = 0;
   localparam int CLR_OVF_BIT = 1;

endpackage

// File: rtl/button_event_scheduler_fifo.sv
// rtl/button_event_scheduler_fifo.sv - circular event queue with flush
module event_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   input  logic                   flush,
   output logic [WIDTH-1:0]       head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   // A push into a full queue is legal only when the head leaves on the same edge.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/button_event_scheduler.sv
// rtl/button_event_scheduler.sv - button event pending/arbiter/queue with AHB-Lite drain port
module button_event_scheduler
   import button_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic               HCLK,
   input  logic               HRESET,
   input  logic [31:0]        HADDR,
   input  logic [31:0]        HWDATA,
   input  logic               HWRITE,
   input  logic               HREADY,
   input  logic               HSEL,
   input  logic [2:0]         HSIZE,
   input  logic [1:0]         HTRANS,
   input  logic [NUM_SRC-1:0] EventPulse,
   output logic [31:0]        HRDATA,
   output logic               HREADYOUT,
   output logic               IRQ
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic               ap_valid;
   logic               ap_write;
   logic [1:0]         ap_offset;
   logic [NUM_SRC-1:0] mask;
   logic [NUM_SRC-1:0] pending;
   logic [SRC_W-1:0]   rr_ptr;
   logic               ovf;

   logic [SRC_W-1:0]   fifo_head;
   logic [CNT_W-1:0]   fifo_count;
   logic               fifo_full;
   logic               fifo_empty;

   logic               rd_event, wr_mask, wr_ctrl;
   logic               pop, push, flush, clr_ovf;
   logic [NUM_SRC-1:0] accepted, loss, grant_oh, keep_mask;
   logic               grant_valid;
   logic [SRC_W-1:0]   grant_idx;
   logic [SRC_W-1:0]   cand;
   logic               unused_ok;

   assign HREADYOUT = 1'b1;
   assign IRQ       = (fifo_count != '0);
   assign unused_ok = ^{HADDR[31:4], HADDR[1:0], HWDATA[31:NUM_SRC], HSIZE};

   assign rd_event  = ap_valid && !ap_write && (ap_offset == REG_EVENT);
   assign wr_mask   = ap_valid &&  ap_write && (ap_offset == REG_MASK);
   assign wr_ctrl   = ap_valid &&  ap_write && (ap_offset == REG_CTRL);
   assign pop       = rd_event && !fifo_empty;
   assign flush     = wr_ctrl && HWDATA[FLUSH_BIT];
   assign clr_ovf   = wr_ctrl && HWDATA[CLR_OVF_BIT];
   assign accepted  = EventPulse & mask;
   assign loss      = accepted & pending;
   assign push      = grant_valid && (!fifo_full || pop) && !flush;
   assign keep_mask = wr_mask ? HWDATA[NUM_SRC-1:0] : '1;

   // Round-robin search starting at the pointer; the first pending source wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         cand = rr_ptr + SRC_W'(i);
         if (!grant_valid && pending[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_comb begin
      grant_oh = '0;
      if (push) grant_oh[grant_idx] = 1'b1;
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         ap_valid  <= 1'b0;
         ap_write  <= 1'b0;
         ap_offset <= '0;
         mask      <= '1;
         pending   <= '0;
         rr_ptr    <= '0;
         ovf       <= 1'b0;
      end else begin
         ap_valid  <= HSEL && HREADY && (HTRANS != 2'b00);
         ap_write  <= HWRITE;
         ap_offset <= HADDR[3:2];
         if (wr_mask) mask <= HWDATA[NUM_SRC-1:0];
         // Pulses landing in the flush cycle are dropped outright and cannot flag overflow.
         if (flush) begin
            pending <= '0;
            ovf     <= ovf && !clr_ovf;
         end else begin
            pending <= (pending | accepted) & ~grant_oh & keep_mask;
            ovf     <= (ovf && !clr_ovf) || (|loss);
         end
         if (push) rr_ptr <= grant_idx + 1'b1;
      end
   end

   always_comb begin
      HRDATA = '0;
      if (ap_valid && !ap_write) begin
         case (ap_offset)
            REG_EVENT: begin
               if (!fifo_empty) begin
                  HRDATA[VALID_BIT]   = 1'b1;
                  HRDATA[SRC_W-1:0]   = fifo_head;
               end
            end
            REG_STATUS: begin
               HRDATA[CNT_W-1:0]          = fifo_count;
               HRDATA[PEND_LSB +: NUM_SRC] = pending;
               HRDATA[OVF_BIT]             = ovf;
            end
            REG_MASK: HRDATA[NUM_SRC-1:0] = mask;
            default:  HRDATA = '0;
         endcase
      end
   end

   event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (SRC_W)
   ) u_fifo (
      .clk       (HCLK),
      .rst       (HRESET),
      .push      (push),
      .push_data (grant_idx),
      .pop       (pop),
      .flush     (flush),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_button_event_scheduler.sv
// tb/tb_button_event_scheduler.sv - directed scoreboard bench for button_event_scheduler
module tb_button_event_scheduler;
   import button_pkg::*;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic [31:0] HADDR;
   logic [31:0] HWDATA;
   logic        HWRITE;
   logic        HREADY;
   logic        HSEL;
   logic [2:0]  HSIZE;
   logic [1:0]  HTRANS;
   logic [3:0]  EventPulse;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic        IRQ;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] rd;

   button_event_scheduler dut (
      .HCLK       (HCLK),
      .HRESET     (HRESET),
      .HADDR      (HADDR),
      .HWDATA     (HWDATA),
      .HWRITE     (HWRITE),
      .HREADY     (HREADY),
      .HSEL       (HSEL),
      .HSIZE      (HSIZE),
      .HTRANS     (HTRANS),
      .EventPulse (EventPulse),
      .HRDATA     (HRDATA),
      .HREADYOUT  (HREADYOUT),
      .IRQ        (IRQ)
   );

   always #5 HCLK = ~HCLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic pulse(input logic [3:0] p);
      EventPulse = p;
      tick();
      EventPulse = 4'h0;
   endtask

   task automatic ahb_read(input logic [1:0] off, output logic [31:0] d);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'h0, off, 2'b00};
      tick();
      HSEL = 1'b0; HTRANS = 2'b00;
      @(negedge HCLK);
      d = HRDATA;
      tick();
   endtask

   task automatic ahb_write(input logic [1:0] off, input logic [31:0] data, input logic [3:0] p);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'h0, off, 2'b00};
      tick();
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
      HWDATA = data; EventPulse = p;
      tick();
      HWDATA = 32'h0; EventPulse = 4'h0;
   endtask

   task automatic read_event(input string tag);
      logic [31:0] d;
      logic [31:0] e;
      ahb_read(REG_EVENT, d);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h0;
      chk(tag, d, e);
   endtask

   function automatic logic [31:0] ev(input src_e s);
      return {1'b1, 29'h0, s};
   endfunction

   initial begin
      HRESET = 1'b1; HADDR = '0; HWDATA = '0; HWRITE = 1'b0; HREADY = 1'b1;
      HSEL = 1'b0; HSIZE = 3'b010; HTRANS = 2'b00; EventPulse = 4'h0;
      tick(); tick();
      HRESET = 1'b0;
      chk("reset_irq", {31'h0, IRQ}, 32'h0);
      chk("reset_hrdata", HRDATA, 32'h0);
      chk("hreadyout", {31'h0, HREADYOUT}, 32'h1);
      ahb_read(REG_MASK, rd);   chk("reset_mask", rd, 32'hF);
      ahb_read(REG_STATUS, rd); chk("reset_status", rd, 32'h0);

      // Single Mode pulse: IRQ rises two cycles after the pulse cycle.
      tick();
      pulse(4'h2);
      exp_q.push_back(ev(MODE));
      @(negedge HCLK); chk("irq_n1", {31'h0, IRQ}, 32'h0);
      tick();
      @(negedge HCLK); chk("irq_n2", {31'h0, IRQ}, 32'h1);
      tick();
      read_event("mode_event");
      chk("irq_after_pop", {31'h0, IRQ}, 32'h0);
      ahb_read(REG_STATUS, rd); chk("status_after_pop", rd, 32'h0);

      // All four at once from pointer 0, twice.
      HRESET = 1'b1; tick(); HRESET = 1'b0;
      for (int b = 0; b < 2; b++) begin
         pulse(4'hF);
         for (int s = 0; s < 4; s++) exp_q.push_back({1'b1, 29'h0, 2'(s)});
         repeat (5) tick();
         ahb_read(REG_STATUS, rd); chk("burst_count", rd, 32'h4);
         for (int s = 0; s < 4; s++) read_event("burst_event");
      end

      // Trip pulses until the queue is full, one pending, then an overflow.
      for (int k = 0; k < 5; k++) begin
         pulse(4'h4);
         tick();
         exp_q.push_back(ev(TRIP));
      end
      ahb_read(REG_STATUS, rd); chk("trip_full", rd, 32'h0000_0404);
      pulse(4'h4);
      tick();
      ahb_read(REG_STATUS, rd); chk("trip_ovf", rd, 32'h0001_0404);
      ahb_write(REG_CTRL, 32'h2, 4'h0);
      ahb_read(REG_STATUS, rd); chk("ovf_cleared", rd, 32'h0000_0404);
      read_event("trip_pop_push");
      ahb_read(REG_STATUS, rd); chk("trip_refill", rd, 32'h0000_0004);
      for (int k = 0; k < 4; k++) read_event("trip_drain");

      // Full queue with Setting pending; a pop lets it in on the same edge.
      pulse(4'h1); tick(); exp_q.push_back(ev(DAYNIGHT));
      pulse(4'h2); tick(); exp_q.push_back(ev(MODE));
      pulse(4'h4); tick(); exp_q.push_back(ev(TRIP));
      pulse(4'h1); tick(); exp_q.push_back(ev(DAYNIGHT));
      pulse(4'h8); tick(); exp_q.push_back(ev(SETTING));
      ahb_read(REG_STATUS, rd); chk("setting_pending", rd, 32'h0000_0804);
      read_event("full_pop");
      ahb_read(REG_STATUS, rd); chk("full_swap_count", rd, 32'h0000_0004);
      for (int k = 0; k < 4; k++) read_event("full_drain");

      // Masked Mode is ignored; unmasked Mode queues.
      ahb_write(REG_MASK, 32'hD, 4'h0);
      ahb_read(REG_MASK, rd); chk("mask_d", rd, 32'hD);
      pulse(4'h2);
      repeat (3) tick();
      chk("masked_irq", {31'h0, IRQ}, 32'h0);
      ahb_read(REG_STATUS, rd); chk("masked_status", rd, 32'h0);
      ahb_write(REG_MASK, 32'hF, 4'h0);
      pulse(4'h2);
      exp_q.push_back(ev(MODE));
      tick();
      chk("unmasked_irq", {31'h0, IRQ}, 32'h1);
      read_event("unmasked_event");

      // Flush with three queued and a simultaneous pulse.
      pulse(4'h4); pulse(4'h2); pulse(4'h8);
      repeat (3) tick();
      ahb_read(REG_STATUS, rd); chk("pre_flush", rd, 32'h3);
      ahb_write(REG_CTRL, 32'h1, 4'hF);
      chk("flush_irq", {31'h0, IRQ}, 32'h0);
      ahb_read(REG_STATUS, rd); chk("flush_status", rd, 32'h0);
      ahb_read(REG_EVENT, rd); chk("flush_event_empty", rd, 32'h0);

      // Reset in the middle of activity.
      ahb_write(REG_MASK, 32'h3, 4'h0);
      pulse(4'h2);
      tick();
      HRESET = 1'b1; tick(); HRESET = 1'b0;
      chk("midreset_irq", {31'h0, IRQ}, 32'h0);
      chk("midreset_hrdata", HRDATA, 32'h0);
      ahb_read(REG_STATUS, rd); chk("midreset_status", rd, 32'h0);
      ahb_read(REG_MASK, rd);   chk("midreset_mask", rd, 32'hF);
      ahb_read(REG_EVENT, rd);  chk("midreset_event", rd, 32'h0);

      chk("scoreboard_empty", exp_q.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
